// File: rtl/edge_capture_pkg.sv
// Shared constants and sizing helpers for the edge-capture block and its upstream array.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package edge_capture_pkg;

  localparam int DEFAULT_WIDTH = 3;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // One queued event holds the captured value plus the toggle mask.
  function automatic int entry_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/edge_capture_fifo_if.sv
// Event output handshake: head entry value/mask with valid/ready.
// Latency: none (wires only).
// Backpressure: consumer holds out_ready low to keep the head presented.
interface edge_capture_fifo_if #(
  parameter int WIDTH = 3
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic [WIDTH-1:0] out_mask;

  modport master (
    output out_valid,
    output out_value,
    output out_mask,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    input  out_mask,
    output out_ready
  );
endinterface

// File: rtl/edge_capture_fifo_fifo.sv
// Circular event queue with power-of-2 depth; storage is not reset.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module event_fifo
  import edge_capture_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers (wrap naturally at DEPTH) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are only observed through a non-empty head.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/edge_capture_fifo.sv
// Detects toggles on in_bits and queues {value, mask} events for a consumer.
// Latency: event at edge N is presented after edge N when the queue was empty.
// Backpressure: out_ready low holds the head; events arriving while full are dropped and flag overflow.
module edge_capture_fifo
  import edge_capture_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_bits,
  edge_capture_fifo_if.master   out_if,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  input  logic                  clear_ovf
);

  localparam int EW = entry_w(WIDTH);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             primed_q, primed_d;
  logic             overflow_q, overflow_d;

  logic             evt;
  logic [WIDTH-1:0] evt_mask;
  logic             head_vld;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    head_dat;

  // The first edge after reset only loads prev; no event can fire from the reset value.
  assign evt      = primed_q && (in_bits != prev_q);
  assign evt_mask = in_bits ^ prev_q;
  assign head_vld = !fifo_empty;
  assign pop      = head_vld && out_if.out_ready;
  assign drop     = evt && fifo_full && !pop;

  // Next-state for history, priming and the sticky overflow (a new drop beats a clear).
  always_comb begin
    prev_d     = in_bits;
    primed_d   = 1'b1;
    overflow_d = drop | (overflow_q & ~clear_ovf);
  end

  // Detection and overflow state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
    end
  end

  event_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (EW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (evt),
    .pop_i   (pop),
    .wdata_i ({in_bits, evt_mask}),
    .rdata_o (head_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Head fields are gated so stale storage never leaks out while empty.
  assign out_if.out_valid = head_vld;
  assign out_if.out_value = head_vld ? head_dat[EW-1:WIDTH] : '0;
  assign out_if.out_mask  = head_vld ? head_dat[WIDTH-1:0]  : '0;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_edge_capture_fifo.sv
// Bench for edge_capture_fifo (WIDTH=3, DEPTH=4): vector table, scoreboard model, corner sequences.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: out_ready is driven per step from the stimulus.
module tb_edge_capture_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] in_bits;
  logic [2:0] count;
  logic       overflow;
  logic       clear_ovf;

  edge_capture_fifo_if #(.WIDTH(3)) out_if ();

  edge_capture_fifo #(.WIDTH(3), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_bits   (in_bits),
    .out_if    (out_if),
    .count     (count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [5:0] sb[$];
  logic [2:0] m_prev;
  logic       m_primed;
  logic       m_ovf;

  typedef struct packed {
    logic [2:0] in_b;
    logic       rdy;
    logic       clr;
    logic       vld;
    logic [2:0] val;
    logic [2:0] msk;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_prev   = 3'b000;
    m_primed = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Drive one cycle, advance the model, then compare all outputs after the edge.
  task automatic step(input logic [2:0] b, input logic rdy, input logic clr);
    logic full, pop, evt, drop;
    in_bits          = b;
    out_if.out_ready = rdy;
    clear_ovf        = clr;
    full = (sb.size() == 4);
    pop  = (sb.size() > 0) && rdy;
    evt  = m_primed && (b != m_prev);
    drop = 1'b0;
    if (pop) void'(sb.pop_front());
    if (evt) begin
      if (!full || pop) sb.push_back({b, b ^ m_prev});
      else drop = 1'b1;
    end
    m_ovf    = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_prev   = b;
    m_primed = 1'b1;
    @(posedge clock);
    #1;
    chk("sb_valid", int'(out_if.out_valid), int'(sb.size() > 0));
    chk("sb_count", int'(count), sb.size());
    chk("sb_ovf", int'(overflow), int'(m_ovf));
    if (sb.size() > 0) begin
      chk("sb_value", int'(out_if.out_value), int'(sb[0][5:3]));
      chk("sb_mask", int'(out_if.out_mask), int'(sb[0][2:0]));
    end else begin
      chk("sb_value_idle", int'(out_if.out_value), 0);
      chk("sb_mask_idle", int'(out_if.out_mask), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset then 3'b100 held; one event 011/111; two queued events; empty-ready no-op.
    tbl[0]  = '{3'b100, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0};
    tbl[1]  = '{3'b100, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0};
    tbl[2]  = '{3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0};
    tbl[3]  = '{3'b011, 1'b1, 1'b0, 1'b1, 3'b011, 3'b111, 3'd1, 1'b0};
    tbl[4]  = '{3'b011, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0};
    tbl[5]  = '{3'b011, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0};
    tbl[6]  = '{3'b010, 1'b0, 1'b0, 1'b1, 3'b010, 3'b001, 3'd1, 1'b0};
    tbl[7]  = '{3'b110, 1'b0, 1'b0, 1'b1, 3'b010, 3'b001, 3'd2, 1'b0};
    tbl[8]  = '{3'b110, 1'b1, 1'b0, 1'b1, 3'b110, 3'b100, 3'd1, 1'b0};
    tbl[9]  = '{3'b110, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0};
    tbl[10] = '{3'b110, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'd0, 1'b0};

    reset            = 1'b1;
    in_bits          = 3'b000;
    clear_ovf        = 1'b0;
    out_if.out_ready = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_valid", int'(out_if.out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_value", int'(out_if.out_value), 0);
    #3 reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].in_b, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), int'(out_if.out_valid), int'(tbl[i].vld));
      chk($sformatf("tbl%0d_value", i), int'(out_if.out_value), int'(tbl[i].val));
      chk($sformatf("tbl%0d_mask", i), int'(out_if.out_mask), int'(tbl[i].msk));
      chk($sformatf("tbl%0d_count", i), int'(count), int'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
    end

    // Five bit0 toggles with no consumer: four stored, the fifth dropped.
    step(3'b111, 1'b0, 1'b0);
    step(3'b110, 1'b0, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    step(3'b110, 1'b0, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    chk("ovf5_count", int'(count), 4);
    chk("ovf5_flag", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_mask", i), int'(out_if.out_mask), 1);
      step(3'b111, 1'b1, 1'b0);
    end
    chk("drain_count", int'(count), 0);
    chk("drain_ovf_sticky", int'(overflow), 1);
    step(3'b111, 1'b0, 1'b1);
    chk("clear_ovf", int'(overflow), 0);

    // Full queue with simultaneous push and pop.
    step(3'b110, 1'b0, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    step(3'b110, 1'b0, 1'b0);
    step(3'b111, 1'b0, 1'b0);
    chk("full_count", int'(count), 4);
    step(3'b110, 1'b1, 1'b0);
    chk("full_pushpop_count", int'(count), 4);
    chk("full_pushpop_ovf", int'(overflow), 0);

    // Drop and clear on the same edge: set wins; clear alone next cycle.
    step(3'b111, 1'b0, 1'b1);
    chk("set_beats_clear", int'(overflow), 1);
    step(3'b111, 1'b0, 1'b1);
    chk("clear_alone", int'(overflow), 0);

    // Mid-cycle reset with three entries queued.
    step(3'b111, 1'b1, 1'b0);
    chk("pre_rst_count", int'(count), 3);
    #3 reset = 1'b1;
    #1;
    chk("midrst_valid", int'(out_if.out_valid), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_value", int'(out_if.out_value), 0);
    chk("midrst_mask", int'(out_if.out_mask), 0);
    chk("midrst_ovf", int'(overflow), 0);
    #2 reset = 1'b0;
    model_reset();
    step(3'b010, 1'b0, 1'b0);
    chk("prime_no_event", int'(count), 0);
    step(3'b011, 1'b0, 1'b0);
    chk("post_prime_event", int'(count), 1);
    chk("post_prime_mask", int'(out_if.out_mask), 1);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      logic [2:0] rb;
      rb = 3'($urandom_range(0, 7));
      step(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 6; i++) begin
      step(in_bits, 1'b1, 1'b0);
    end
    chk("final_count", int'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
